// File: rtl/mul32_seq_sched.sv
// Unsigned 32x32 multiply scheduled onto one shared external 16x16 multiplier.
// Partial products LL, HL, LH, HH are issued one per cycle and accumulated.
module mul32_seq_sched #(
   parameter int Y_WIDTH   = 64,
   parameter bit SKIP_ZERO = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_a,
   input  logic [31:0]        in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [Y_WIDTH-1:0] out_y,
   output logic [15:0]        mul_a,
   output logic [15:0]        mul_b,
   input  logic [31:0]        mul_p,
   output logic               busy
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   state_t             state_q;
   logic [31:0]        a_q, b_q;
   logic [3:0]         mask_q, done_q;
   logic [Y_WIDTH-1:0] acc_q;

   logic [3:0]         mask_d, pend, sel;
   logic [5:0]         shamt;
   logic [63:0]        term;
   logic [Y_WIDTH-1:0] acc_d;
   logic               last;

   // Step enables from the incoming operands: LL, HL, LH, HH.
   always_comb begin
      mask_d    = 4'b1111;
      if (SKIP_ZERO) begin
         mask_d[0] = (in_a[15:0]  != 16'd0) && (in_b[15:0]  != 16'd0);
         mask_d[1] = (in_a[31:16] != 16'd0) && (in_b[15:0]  != 16'd0);
         mask_d[2] = (in_a[15:0]  != 16'd0) && (in_b[31:16] != 16'd0);
         mask_d[3] = (in_a[31:16] != 16'd0) && (in_b[31:16] != 16'd0);
      end
      if (Y_WIDTH == 32) mask_d[3] = 1'b0;
   end

   assign pend = mask_q & ~done_q;
   assign sel  = pend & (~pend + 4'd1);
   assign last = ((pend & ~sel) == 4'd0);

   always_comb begin
      mul_a = 16'd0;
      mul_b = 16'd0;
      shamt = 6'd0;
      if (state_q == S_MUL) begin
         if (pend[0]) begin
            mul_a = a_q[15:0];  mul_b = b_q[15:0];  shamt = 6'd0;
         end else if (pend[1]) begin
            mul_a = a_q[31:16]; mul_b = b_q[15:0];  shamt = 6'd16;
         end else if (pend[2]) begin
            mul_a = a_q[15:0];  mul_b = b_q[31:16]; shamt = 6'd16;
         end else if (pend[3]) begin
            mul_a = a_q[31:16]; mul_b = b_q[31:16]; shamt = 6'd32;
         end
      end
   end

   assign term  = {32'd0, mul_p} << shamt;
   assign acc_d = acc_q + term[Y_WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         mask_q  <= 4'd0;
         done_q  <= 4'd0;
         acc_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (in_valid) begin
               a_q     <= in_a;
               b_q     <= in_b;
               mask_q  <= mask_d;
               done_q  <= 4'd0;
               acc_q   <= '0;
               state_q <= (mask_d != 4'd0) ? S_MUL : S_DONE;
            end
            S_MUL: begin
               acc_q  <= acc_d;
               done_q <= done_q | sel;
               if (last) state_q <= S_DONE;
            end
            S_DONE: if (out_ready) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   // Accumulator is only exposed once complete.
   assign out_y     = (state_q == S_DONE) ? acc_q : '0;

endmodule

// File: tb/tb_mul32_seq_sched.sv
// Directed bench: three configurations (64/skip, 64/no-skip, 32/skip) driven in lockstep.
module tb_mul32_seq_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, out_ready;
   logic [31:0] in_a, in_b;
   logic [2:0]  in_ready, out_valid, busy;
   logic [63:0] y0, y1;
   logic [31:0] y2;
   logic [2:0][15:0] ma, mb;
   logic [2:0][31:0] mp;

   int n_vec = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   for (genvar i = 0; i < 3; i++) begin : g_mul
      assign mp[i] = {16'd0, ma[i]} * {16'd0, mb[i]};
   end

   mul32_seq_sched #(.Y_WIDTH(64), .SKIP_ZERO(1'b1)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid[0]), .out_ready(out_ready),
      .out_y(y0), .mul_a(ma[0]), .mul_b(mb[0]), .mul_p(mp[0]), .busy(busy[0]));

   mul32_seq_sched #(.Y_WIDTH(64), .SKIP_ZERO(1'b0)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid[1]), .out_ready(out_ready),
      .out_y(y1), .mul_a(ma[1]), .mul_b(mb[1]), .mul_p(mp[1]), .busy(busy[1]));

   mul32_seq_sched #(.Y_WIDTH(32), .SKIP_ZERO(1'b1)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid[2]), .out_ready(out_ready),
      .out_y(y2), .mul_a(ma[2]), .mul_b(mb[2]), .mul_p(mp[2]), .busy(busy[2]));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask

   // Issue one op with out_ready high; check result and first-valid cycle (T+k) per instance.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] e0, input int l0, input int l1,
                         input logic [31:0] e2, input int l2);
      int          first [3];
      logic [63:0] yy [3];
      int          mulc0, mulc2;
      bit          nz0;
      first = '{0, 0, 0};
      yy    = '{64'd0, 64'd0, 64'd0};
      mulc0 = 0; mulc2 = 0; nz0 = 1'b0;
      @(negedge clk);
      chk({tag, ".rdy"}, {61'd0, in_ready}, 64'd7);
      in_a = a; in_b = b; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         if (out_valid[0] && first[0] == 0) begin first[0] = cyc; yy[0] = y0; end
         if (out_valid[1] && first[1] == 0) begin first[1] = cyc; yy[1] = y1; end
         if (out_valid[2] && first[2] == 0) begin first[2] = cyc; yy[2] = {32'd0, y2}; end
         if (busy[0] && !out_valid[0]) mulc0++;
         if (busy[2] && !out_valid[2]) mulc2++;
         if ((ma[0] | mb[0]) != 16'd0) nz0 = 1'b1;
         @(negedge clk);
      end
      chk({tag, ".y0"},   yy[0], e0);
      chk({tag, ".lat0"}, 64'(first[0]), 64'(l0));
      chk({tag, ".y1"},   yy[1], e0);
      chk({tag, ".lat1"}, 64'(first[1]), 64'(l1));
      chk({tag, ".y2"},   yy[2], {32'd0, e2});
      chk({tag, ".lat2"}, 64'(first[2]), 64'(l2));
      chk({tag, ".mul0"}, 64'(mulc0), 64'(l0 - 1));
      chk({tag, ".mul2"}, 64'(mulc2), 64'(l2 - 1));
      chk({tag, ".nz0"},  {63'd0, nz0}, {63'd0, l0 > 1});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0;
      repeat (3) @(negedge clk);
      chk("rst.valid", {61'd0, out_valid}, 64'd0);
      chk("rst.busy",  {61'd0, busy}, 64'd0);
      chk("rst.mul",   {16'd0, ma[0], 16'd0, mb[0]}, 64'd0);
      chk("rst.y0",    y0, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst.rdy",   {61'd0, in_ready}, 64'd7);

      run_op("ones",  32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 5, 5, 32'h00000001, 4);
      run_op("ll",    32'h00001234, 32'h00005678, 64'h0000000006260060, 2, 5, 32'h06260060, 2);
      run_op("zero",  32'h00000000, 32'hDEADBEEF, 64'h0,                1, 5, 32'h00000000, 1);
      run_op("hh",    32'h00010000, 32'h00010000, 64'h0000000100000000, 2, 5, 32'h00000000, 1);
      run_op("mix",   32'h00020003, 32'h00040005, 64'h000000080016000F, 5, 5, 32'h0016000F, 4);
      run_op("hl",    32'h00010000, 32'h00000001, 64'h0000000000010000, 2, 5, 32'h00010000, 2);

      // Backpressure: result held, new request ignored until after handshake.
      @(negedge clk);
      out_ready = 1'b0; in_a = 32'd3; in_b = 32'd5; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 0; c < 10 && !out_valid[0]; c++) @(negedge clk);
      chk("bp.valid", {63'd0, out_valid[0]}, 64'd1);
      chk("bp.y",     y0, 64'd15);
      for (int k = 0; k < 3; k++) begin
         in_a = 32'd7; in_b = 32'd9; in_valid = (k % 2 == 0);
         @(negedge clk);
         chk("bp.hold.y",   y0, 64'd15);
         chk("bp.hold.rdy", {63'd0, in_ready[0]}, 64'd0);
         chk("bp.hold.vld", {63'd0, out_valid[0]}, 64'd1);
      end
      out_ready = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      chk("bp.rdy_next", {63'd0, in_ready[0]}, 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp.accept", {63'd0, busy[0]}, 64'd1);
      for (int c = 0; c < 10 && !out_valid[0]; c++) @(negedge clk);
      chk("bp.y2", y0, 64'd63);
      repeat (10) @(negedge clk);

      // Reset during the second MUL cycle.
      in_a = 32'hFFFFFFFF; in_b = 32'hFFFFFFFF; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("mr.busy_pre", {63'd0, busy[0]}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mr.busy",  {61'd0, busy}, 64'd0);
      chk("mr.valid", {61'd0, out_valid}, 64'd0);
      chk("mr.mul",   {16'd0, ma[0], 16'd0, mb[0]}, 64'd0);
      chk("mr.y0",    y0, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post", 32'd3, 32'd5, 64'd15, 2, 5, 32'd15, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/mul32_seq_sched.md
# mul32_seq_sched

Sequential scheduler for an unsigned 32x32 multiply on a single shared 16x16 multiplier. It splits the operands into 16-bit halves and issues the LL, HL, LH and HH partial products one per cycle to an external combinational multiplier. The partial products are accumulated into a 64-bit result, or a 32-bit result when only the low word is needed. It serves as the area-saving alternative to the fully parallel four-multiplier narrowing, for designs where combinator count matters more than latency.

## Interface
Parameters:
- `Y_WIDTH`, 64: result width, 64 or 32. With 32, the HH step is never issued and accumulation wraps mod 2^32.
- `SKIP_ZERO`, 1: when 1, a step whose A-half or B-half operand is zero is skipped.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand request.
- `in_ready` output 1: high only in IDLE.
- `in_a` input 32: multiplicand, unsigned.
- `in_b` input 32: multiplier, unsigned.
- `out_valid` output 1: result available.
- `out_ready` input 1: result consumed.
- `out_y` output Y_WIDTH: product mod 2^Y_WIDTH.
- `mul_a` output 16: shared multiplier operand A.
- `mul_b` output 16: shared multiplier operand B.
- `mul_p` input 32: `mul_a*mul_b`, valid in the same cycle (combinational).
- `busy` output 1: high in MUL or DONE.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - MUL: one step per cycle.
  - DONE: `out_valid`=1.
- Accept: on `in_valid && in_ready`, register `in_a` and `in_b`, clear the accumulator, and build the step mask.
- Step order, fixed:
  - 0: LL = A[15:0]×B[15:0], shift 0.
  - 1: HL = A[31:16]×B[15:0], shift 16.
  - 2: LH = A[15:0]×B[31:16], shift 16.
  - 3: HH = A[31:16]×B[31:16], shift 32.
- Step mask:
  - A step is enabled unless (SKIP_ZERO and either of its halves is 0), or (step 3 and Y_WIDTH=32).
  - The mask is computed at accept from the input operands.
- Each MUL cycle:
  - Select the lowest enabled, unexecuted step.
  - Drive its halves on `mul_a`/`mul_b`.
  - At the clock edge: acc ← acc + (`mul_p` << shift), truncated to Y_WIDTH bits; mark the step done.
- Transitions:
  - IDLE→MUL on accept, if the mask is non-zero.
  - IDLE→DONE on accept, if the mask is zero (acc = 0).
  - MUL→DONE on the edge that executes the last enabled step.
  - DONE→IDLE on `out_valid && out_ready`.
- Datapath widths and values:
  - The accumulator is Y_WIDTH bits. The sum with all steps enabled never exceeds 2^64−1, so the 64-bit mode has no overflow.
  - `out_y` = accumulator, held stable throughout DONE.
  - `mul_a` and `mul_b` are 0 outside MUL.
  - Skipped steps contribute exactly 0, so the result is identical for SKIP_ZERO=0 and SKIP_ZERO=1.
- Reset values: state IDLE, `in_ready`=1 once `rst_n` is high, `out_valid`=0, `out_y`=0, `busy`=0, `mul_a`=0, `mul_b`=0, accumulator and mask 0.
- Reset mid-operation: immediately abandons the operation. No partial result is ever presented.
- `in_valid` while not in IDLE is ignored. The upstream must hold its operands until accepted.

## Timing
- Let T be the accept cycle and N (0..4) the number of enabled steps.
- MUL occupies cycles T+1..T+N.
- `out_valid` is first high in cycle T+1+N:
  - T+5 at most.
  - T+1 for all-zero operands (SKIP_ZERO=1).
- Let U be the cycle of `out_valid && out_ready`. Then IDLE and `in_ready`=1 hold in U+1, so the next accept is at U+1 at the earliest.
- There is no same-cycle re-accept.
- Back-to-back throughput is 1 result per N+2 cycles.
- `in_ready` and `out_valid` are registered state decodes. `mul_a`/`mul_b` are decoded combinationally from state, mask and registered operands. None depends combinationally on `in_valid` or `out_ready`.

## Test plan
- **Full-width, all steps.** Y_WIDTH=64, A=B=0xFFFFFFFF → four MUL cycles issuing (0xFFFF,0xFFFF) each. `out_y`=0xFFFFFFFE00000001, `out_valid` at T+5.
- **LL only.** SKIP_ZERO=1, A=0x00001234, B=0x00005678 → only LL issued. `out_y`=0x0000000006260060, `out_valid` at T+2. With SKIP_ZERO=0: same value at T+5.
- **Zero operand.** SKIP_ZERO=1, A=0, B=0xDEADBEEF → no MUL cycles, `mul_a`/`mul_b` stay 0. `out_y`=0, `out_valid` at T+1.
- **32-bit wrap.** Y_WIDTH=32, SKIP_ZERO=1, A=0x00010000, B=0x00010000 → all steps masked. `out_y`=0x00000000 at T+1. Same bench with A=B=0xFFFFFFFF: `out_y`=0x00000001 at T+4, HH never issued.
- **Backpressure.** Hold `out_ready`=0 for 3 cycles in DONE while pulsing `in_valid` with new operands. `out_y` stays stable, `in_ready` stays 0, the new request is not accepted. Raise `out_ready`: `in_ready`=1 the next cycle, and the new request is accepted then.
- **Reset mid-operation.** Assert `rst_n`=0 during the second MUL cycle. All outputs go to reset values asynchronously. After release, the next operation 3×5 gives `out_y`=15, with no stale accumulator contribution.
